// File: rtl/t03_data_mem_requester_if.sv
// Word-organised data RAM port for the team-03 memory requester.
// Master drives address/strobes/write data, slave returns the read word.
interface t03_data_mem_requester_if;
  logic [31:0] data_address;
  logic        dm_read_en;
  logic        dm_write_en;
  logic [31:0] data_to_write;
  logic [31:0] data_read;

  modport master (
    output data_address,
    output dm_read_en,
    output dm_write_en,
    output data_to_write,
    input  data_read
  );

  modport slave (
    input  data_address,
    input  dm_read_en,
    input  dm_write_en,
    input  data_to_write,
    output data_read
  );
endinterface

// File: rtl/t03_data_mem_requester.sv
// Core-side load/store initiator for the team-03 data RAM.
// Sub-word stores are read-modify-write; sub-word loads are extended.
module t03_data_mem_requester (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  t03_data_mem_requester_if.master dm
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t      state, state_n;
  logic        we_q;
  logic        uns_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [9:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;

  logic        bad;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  // Only addr[9:0] matter: the RAM aliases every 1 KiB.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:10];

  always_comb begin
    bad = 1'b0;
    case (req_size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = req_addr[0];
      2'b10:   bad = |req_addr[1:0];
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (bad)
            state_n = DONE;
          else if (req_we && req_size == 2'b10)
            state_n = WR;
          else
            state_n = RD;
        end
      end
      RD:      state_n = we_q ? WR : DONE;
      WR:      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    lane8 = 8'h00;
    unique case (1'b1)
      addr_q[1:0] == 2'd0: lane8 = dm.data_read[7:0];
      addr_q[1:0] == 2'd1: lane8 = dm.data_read[15:8];
      addr_q[1:0] == 2'd2: lane8 = dm.data_read[23:16];
      addr_q[1:0] == 2'd3: lane8 = dm.data_read[31:24];
    endcase
    lane16 = addr_q[1] ? dm.data_read[31:16]
                       : dm.data_read[15:0];
  end

  always_comb begin
    ld_ext = dm.data_read;
    unique case (1'b1)
      size_q == 2'b00:
        ld_ext = {{24{~uns_q & lane8[7]}}, lane8};
      size_q == 2'b01:
        ld_ext = {{16{~uns_q & lane16[15]}}, lane16};
      default:
        ld_ext = dm.data_read;
    endcase
  end

  always_comb begin
    merged = word_q;
    unique case (1'b1)
      size_q == 2'b00:
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      size_q == 2'b01:
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default:
        merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 10'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata   <= 32'd0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= bad;
        size_q  <= req_size;
        addr_q  <= req_addr[9:0];
        wdata_q <= req_wdata;
      end
      // Load result lands on the edge that enters DONE.
      if (state == RD) begin
        word_q <= dm.data_read;
        if (!we_q)
          rdata <= ld_ext;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = (state == DONE) && err_q;

  assign dm.data_address  = {24'd0, addr_q[9:2]};
  assign dm.dm_read_en    = (state == RD);
  assign dm.dm_write_en   = (state == WR);
  assign dm.data_to_write = (state == WR) ? merged : 32'd0;

endmodule

// File: tb/tb_t03_data_mem_requester.sv
// Randomised bench for t03_data_mem_requester against a byte-array
// memory model; a negedge-sampling RAM model sits on the bus.
module tb_t03_data_mem_requester;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  t03_data_mem_requester_if bus ();

  t03_data_mem_requester dut (
    .clk          (clk),
    .nrst         (nrst),
    .req          (req),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .dm           (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] ref_rdata;
  int total = 0;
  int bad = 0;
  int overlap = 0;
  int repeats = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  always @(negedge clk) begin
    if (bus.dm_write_en)
      mem[bus.data_address[7:0]] <= bus.data_to_write;
    if (bus.dm_read_en)
      bus.data_read <= mem[bus.data_address[7:0]];
  end

  always @(negedge clk) begin
    if (bus.dm_read_en && bus.dm_write_en) overlap++;
    if (bus.dm_read_en && prev_rd) repeats++;
    if (bus.dm_write_en && prev_wr) repeats++;
    prev_rd = bus.dm_read_en;
    prev_wr = bus.dm_write_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = {22'd0, a[9:2], 2'b00};
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic is_bad(input logic [1:0] sz,
                                  input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && a[0]) return 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_store(input logic [1:0] sz,
                             input logic [31:0] a,
                             input logic [31:0] wd);
    int n;
    int b;
    n = 1 << sz;
    b = int'(a[9:0]);
    for (int i = 0; i < n; i++)
      ref_mem[b+i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] sz,
                                             input logic un,
                                             input logic [31:0] a);
    int n;
    int b;
    logic [31:0] v;
    n = 1 << sz;
    b = int'(a[9:0]);
    v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[b+i]) << (8*i));
    if (!un && n == 1 && v[7]) v = v | 32'hFFFF_FF00;
    if (!un && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic reset_check(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_rden"}, 32'(bus.dm_read_en), 0);
    chk({tag, "_wren"}, 32'(bus.dm_write_en), 0);
    chk({tag, "_addr"}, bus.data_address, 0);
    chk({tag, "_wdata"}, bus.data_to_write, 0);
  endtask

  task automatic run_op(input logic we,
                        input logic [1:0] sz,
                        input logic un,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] wr_word);
    logic e;
    int exp_lat;
    int exp_rd;
    int exp_wr;
    int cyc;
    int rd_n;
    int wr_n;
    int addr_bad;
    logic got_done;
    logic got_err;
    e = is_bad(sz, a);
    exp_rd = (!e && (!we || sz != 2'd2)) ? 1 : 0;
    exp_wr = (!e && we) ? 1 : 0;
    exp_lat = e ? 1 : 1 + exp_rd + exp_wr;
    @(negedge clk);
    req = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = un;
    req_addr = a;
    req_wdata = wd;
    cyc = 0;
    rd_n = 0;
    wr_n = 0;
    addr_bad = 0;
    got_done = 1'b0;
    got_err = 1'b0;
    wr_word = 32'd0;
    while (!got_done && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (bus.dm_read_en || bus.dm_write_en)
        if (bus.data_address != {24'd0, a[9:2]}) addr_bad++;
      if (bus.dm_read_en) rd_n++;
      if (bus.dm_write_en) begin
        wr_n++;
        wr_word = bus.data_to_write;
      end
      if (done) begin
        got_done = 1'b1;
        got_err = err;
      end
    end
    req = 1'b0;
    if (!e) begin
      if (we) model_store(sz, a, wd);
      else ref_rdata = model_load(sz, un, a);
    end
    chk("done_seen", 32'(got_done), 1);
    chk("latency", cyc, exp_lat);
    chk("err", 32'(got_err), 32'(e));
    chk("rd_strobes", rd_n, exp_rd);
    chk("wr_strobes", wr_n, exp_wr);
    chk("bus_addr", addr_bad, 0);
    chk("rdata", rdata, ref_rdata);
    if (we && !e) chk("wr_word", wr_word, ref_word(a));
  endtask

  logic [31:0] w;
  int stray;
  int mm;

  initial begin
    nrst = 1'b0;
    req = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    ref_rdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      for (int k = 0; k < 4; k++)
        ref_mem[4*i+k] = mem[i][8*k +: 8];
    end
    repeat (2) @(negedge clk);
    reset_check("reset");
    nrst = 1'b1;

    run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, w);
    chk("word_store", w, 32'hDEADBEEF);
    run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, w);
    chk("word_load", rdata, 32'hDEADBEEF);

    run_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, w);
    run_op(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, w);
    chk("byte_rmw", w, 32'h11AA3344);

    run_op(1'b1, 2'd2, 1'b0, 32'h30, 32'h80F07F01, w);
    run_op(1'b0, 2'd0, 1'b0, 32'h32, 32'h0, w);
    chk("lb_signed", rdata, 32'hFFFFFFF0);
    run_op(1'b0, 2'd0, 1'b1, 32'h32, 32'h0, w);
    chk("lb_unsigned", rdata, 32'h000000F0);
    run_op(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, w);
    chk("lh_signed", rdata, 32'hFFFF80F0);

    run_op(1'b0, 2'd1, 1'b0, 32'h31, 32'h0, w);
    run_op(1'b1, 2'd2, 1'b0, 32'h42, 32'h12345678, w);
    run_op(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, w);
    chk("err_rdata_held", rdata, 32'hFFFF80F0);

    run_op(1'b1, 2'd2, 1'b0, 32'h404, 32'hCAFEF00D, w);
    run_op(1'b0, 2'd2, 1'b0, 32'h004, 32'h0, w);
    chk("alias", rdata, 32'hCAFEF00D);

    // Inputs change while busy: only the accepted request may act.
    @(negedge clk);
    req = 1'b1;
    req_we = 1'b1;
    req_size = 2'd2;
    req_addr = 32'h50;
    req_wdata = 32'h12345678;
    @(negedge clk);
    chk("busy_c1", 32'(busy), 1);
    req_addr = 32'h54;
    req_wdata = 32'h0BADBAD0;
    @(negedge clk);
    chk("done_c2", 32'(done), 1);
    req = 1'b0;
    model_store(2'd2, 32'h50, 32'h12345678);
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || bus.dm_read_en || bus.dm_write_en) stray++;
    end
    chk("ignored_req", stray, 0);
    chk("mem_50", mem[8'h14], 32'h12345678);
    chk("mem_54", mem[8'h15], ref_word(32'h54));

    // Reset lands while the RMW read is in flight.
    @(negedge clk);
    req = 1'b1;
    req_we = 1'b1;
    req_size = 2'd0;
    req_addr = 32'h61;
    req_wdata = 32'h55;
    @(negedge clk);
    chk("midrst_rd", 32'(bus.dm_read_en), 1);
    #1;
    nrst = 1'b0;
    req = 1'b0;
    #1;
    ref_rdata = 32'd0;
    reset_check("midrst");
    stray = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) stray++;
    end
    nrst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    chk("midrst_nodone", stray, 0);
    chk("midrst_mem", mem[8'h18], ref_word(32'h60));

    for (int n = 0; n < 150; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run_op(1'($urandom), sz, 1'($urandom), a, $urandom, w);
    end

    @(negedge clk);
    chk("strobe_overlap", overlap, 0);
    chk("strobe_repeat", repeats, 0);
    mm = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_word(32'(4*i))) mm++;
    chk("mem_final", mm, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
